// File: rtl/audio_pkg.sv
// Shared types and sizing for the audio blocks (clip buffer, I2S path).
package audio_pkg;
    localparam int SAMPLE_BITS = 16;
    localparam int CLIP_LEN    = 256;
    localparam int IDX_BITS    = 8;

    typedef logic signed [SAMPLE_BITS-1:0] sample_t;
    typedef logic [IDX_BITS-1:0]           idx_t;
    typedef logic [IDX_BITS:0]             level_t;

    typedef enum logic {
        FILLING = 1'b0,
        FULL    = 1'b1
    } wr_state_e;
endpackage

// File: rtl/clip_bank_ram.sv
// One clip bank: single write port, single synchronous read port, contents not reset.
module clip_bank_ram
    import audio_pkg::*;
(
    input  logic                   mclk,
    input  logic                   we,
    input  logic [IDX_BITS-1:0]    waddr,
    input  logic [SAMPLE_BITS-1:0] wdata,
    input  logic [IDX_BITS-1:0]    raddr,
    output logic [SAMPLE_BITS-1:0] rdata
);
    logic [SAMPLE_BITS-1:0] mem [CLIP_LEN];

    always_ff @(posedge mclk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/clip_pingpong_buffer.sv
// Ping-pong clip store feeding the I2S transmitter; banks swap when rd_index wraps.
// Build option CLIP_BUF_ZERO_ON_UNDERRUN_EN mutes rd_sample from an underrun until the next swap.
module clip_pingpong_buffer
    import audio_pkg::*;
(
    input  logic                   mclk,
    input  logic                   rst_n,
    input  logic [SAMPLE_BITS-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [IDX_BITS-1:0]    rd_index,
    output logic [SAMPLE_BITS-1:0] rd_sample,
    output logic                   swap_pulse,
    output logic                   underrun,
    output logic [IDX_BITS:0]      fill_level
);
    localparam level_t LAST_PTR = level_t'(CLIP_LEN - 1);
    localparam level_t FULL_PTR = level_t'(CLIP_LEN);
    localparam idx_t   LAST_IDX = idx_t'(CLIP_LEN - 1);

    wr_state_e state;
    level_t    wr_ptr;
    idx_t      idx_q;
    logic      active_bank;
    logic      primed;
    logic      muted;
    logic      accept;
    logic      last_accept;
    logic      wrap;
    logic      do_swap;
    logic      rd_valid_q;
    logic      rd_bank_q;
    logic [SAMPLE_BITS-1:0] bank_q [2];

    // wr_ptr never passes CLIP_LEN: the guard keeps a stray accept from wrapping it
    assign accept      = s_valid && s_ready && (wr_ptr != FULL_PTR);
    assign last_accept = accept && (wr_ptr == LAST_PTR);
    assign wrap        = (idx_q == LAST_IDX) && (rd_index == '0);
    assign do_swap     = wrap && ((state == FULL) || last_accept);
    assign fill_level  = wr_ptr;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILLING;
            wr_ptr      <= '0;
            idx_q       <= '0;
            active_bank <= 1'b0;
            primed      <= 1'b0;
            s_ready     <= 1'b0;
            swap_pulse  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            idx_q      <= rd_index;
            swap_pulse <= do_swap;
            underrun   <= wrap && !do_swap;
            if (do_swap) begin
                // the final beat (if any) lands in the old shadow on this same edge
                active_bank <= ~active_bank;
                wr_ptr      <= '0;
                state       <= FILLING;
                s_ready     <= 1'b1;
                primed      <= 1'b1;
            end else begin
                case (state)
                    FILLING: begin
                        s_ready <= 1'b1;
                        if (accept) begin
                            wr_ptr <= wr_ptr + level_t'(1);
                            if (last_accept) begin
                                state   <= FULL;
                                s_ready <= 1'b0;
                            end
                        end
                    end
                    FULL: s_ready <= 1'b0;
                    default: begin
                        state   <= FILLING;
                        s_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef CLIP_BUF_ZERO_ON_UNDERRUN_EN
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n)
            muted <= 1'b0;
        else if (do_swap)
            muted <= 1'b0;
        else if (wrap)
            muted <= 1'b1;
    end
`else
    assign muted = 1'b0;
`endif

    // The shadow bank (the one not being read) takes producer writes
    for (genvar b = 0; b < 2; b++) begin : g_bank
        clip_bank_ram u_ram (
            .mclk  (mclk),
            .we    (accept && (active_bank == (b == 0))),
            .waddr (wr_ptr[IDX_BITS-1:0]),
            .wdata (s_data),
            .raddr (rd_index),
            .rdata (bank_q[b])
        );
    end

    // Bank select and gating are captured alongside the RAM read so the output
    // reflects the bank active in the cycle rd_index was presented.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_bank_q  <= 1'b0;
        end else begin
            rd_valid_q <= primed && !muted && ({1'b0, rd_index} < FULL_PTR);
            rd_bank_q  <= active_bank;
        end
    end

    assign rd_sample = rd_valid_q ? bank_q[rd_bank_q] : '0;
endmodule

// File: tb/tb_clip_pingpong_buffer.sv
// Directed bench for clip_pingpong_buffer: stimulus pushes expected events/reads,
// a negedge monitor pops and compares whenever the DUT strobes or a read lands.
`timescale 1ns/1ps
module tb_clip_pingpong_buffer;
    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  rd_index = '0;
    logic [15:0] rd_sample;
    logic        swap_pulse;
    logic        underrun;
    logic [8:0]  fill_level;

    localparam int EV_SWAP = 2;
    localparam int EV_UNDR = 1;

    always #5 mclk = ~mclk;

    clip_pingpong_buffer dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .rd_index   (rd_index),
        .rd_sample  (rd_sample),
        .swap_pulse (swap_pulse),
        .underrun   (underrun),
        .fill_level (fill_level)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int evt_q[$];
    int rd_q[$];
    logic rd_probe = 1'b0;
    logic probe_d  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge mclk) probe_d <= rd_probe;

    always @(negedge mclk) begin
        if (swap_pulse || underrun) begin
            if (evt_q.size() == 0)
                chk("unexpected_event", int'({swap_pulse, underrun}), 0);
            else
                chk("event", int'({swap_pulse, underrun}), evt_q.pop_front());
        end
        if (probe_d) begin
            if (rd_q.size() == 0)
                chk("unexpected_read", int'(rd_sample), -1);
            else
                chk("rd_sample", int'(rd_sample), rd_q.pop_front());
        end
    end

    task automatic send(input int v);
        int guard = 0;
        do begin
            @(negedge mclk);
            s_valid = 1'b1;
            s_data  = 16'(v);
            guard++;
        end while (!s_ready && guard < 50);
        if (!s_ready) chk("send_timeout_s_ready", 0, 1);
    endtask

    task automatic stream(input int base, input int n);
        for (int i = 0; i < n; i++) send(base + i);
        @(negedge mclk);
        s_valid = 1'b0;
    endtask

    task automatic read(input int idx, input int exp);
        @(negedge mclk);
        rd_index = 8'(idx);
        rd_probe = 1'b1;
        rd_q.push_back(exp);
        @(negedge mclk);
        rd_probe = 1'b0;
    endtask

    task automatic do_wrap(input int ev);
        @(negedge mclk);
        rd_index = 8'd255;
        repeat (2) @(negedge mclk);
        evt_q.push_back(ev);
        rd_index = 8'd0;
        repeat (3) @(negedge mclk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int guard;
        int mute_exp;
        // 1: reset state
        repeat (3) @(negedge mclk);
        chk("reset_rd_sample", int'(rd_sample), 0);
        chk("reset_s_ready", int'(s_ready), 0);
        chk("reset_fill", int'(fill_level), 0);
        chk("reset_swap", int'(swap_pulse), 0);
        chk("reset_underrun", int'(underrun), 0);
        rst_n = 1'b1;
        chk("s_ready_at_release", int'(s_ready), 0);
        @(negedge mclk);
        chk("s_ready_after_release", int'(s_ready), 1);
        chk("fill_after_release", int'(fill_level), 0);

        // 2: full fill, FULL holds off producer, swap
        stream(0, 256);
        chk("full_s_ready", int'(s_ready), 0);
        chk("full_fill", int'(fill_level), 256);
        s_valid = 1'b1;
        s_data  = 16'd999;
        repeat (3) @(negedge mclk);
        chk("full_fill_hold", int'(fill_level), 256);
        s_valid = 1'b0;
        read(17, 0);
        do_wrap(EV_SWAP);
        chk("swap_fill", int'(fill_level), 0);
        chk("swap_s_ready", int'(s_ready), 1);
        read(17, 17);
        read(0, 0);
        read(255, 255);

        // 3: partial fill then wrap -> underrun, active bank replays (or mutes)
        stream(500, 100);
        do_wrap(EV_UNDR);
        chk("underrun_fill", int'(fill_level), 100);
        chk("underrun_s_ready", int'(s_ready), 1);
`ifdef CLIP_BUF_ZERO_ON_UNDERRUN_EN
        mute_exp = 0;
`else
        mute_exp = 17;
`endif
        read(17, mute_exp);

        // 4: 256th accept on the wrap cycle
        stream(600, 155);
        chk("pre_coincide_fill", int'(fill_level), 255);
        @(negedge mclk);
        rd_index = 8'd255;
        repeat (2) @(negedge mclk);
        chk("pre_coincide_s_ready", int'(s_ready), 1);
        s_valid  = 1'b1;
        s_data   = 16'd755;
        rd_index = 8'd0;
        evt_q.push_back(EV_SWAP);
        @(negedge mclk);
        s_valid = 1'b0;
        chk("coincide_fill", int'(fill_level), 0);
        chk("coincide_s_ready", int'(s_ready), 1);
        read(255, 755);
        read(100, 600);
        read(0, 500);

        // 5: randomly gapped stream, then full readback
        i = 0;
        guard = 0;
        while (i < 256 && guard < 5000) begin
            @(negedge mclk);
            guard++;
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 16'(1000 + i);
            if (s_valid && s_ready) i++;
        end
        @(negedge mclk);
        s_valid = 1'b0;
        chk("random_accepts", i, 256);
        chk("random_fill", int'(fill_level), 256);
        do_wrap(EV_SWAP);
        for (int k = 0; k < 256; k++) read(k, 1000 + k);

        // 6: reset mid-fill discards the partial bank
        stream(2000, 128);
        chk("midfill_level", int'(fill_level), 128);
        rst_n = 1'b0;
        @(negedge mclk);
        chk("midreset_s_ready", int'(s_ready), 0);
        chk("midreset_fill", int'(fill_level), 0);
        chk("midreset_rd_sample", int'(rd_sample), 0);
        chk("midreset_swap", int'(swap_pulse), 0);
        chk("midreset_underrun", int'(underrun), 0);
        rst_n = 1'b1;
        @(negedge mclk);
        chk("rerelease_s_ready", int'(s_ready), 1);
        read(17, 0);
        stream(3000, 256);
        chk("refill_level", int'(fill_level), 256);
        do_wrap(EV_SWAP);
        read(0, 3000);
        read(128, 3128);
        read(255, 3255);

        repeat (4) @(negedge mclk);
        chk("events_drained", evt_q.size(), 0);
        chk("reads_drained", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
